// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver core and the CPU bus: handshakes bytes in, exposes CTRL/RDR/SSR.
// Optional sticky-overrun mode (accept and drop when full) is enabled by defining UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    input  logic        CS,
    input  logic        dbus_we,
    input  logic        dbus_re,
    input  logic [3:0]  dbus_addr,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    localparam logic [3:0] ADDR_CTRL = 4'h0;
    localparam logic [3:0] ADDR_RDR  = 4'h4;
    localparam logic [3:0] ADDR_SSR  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic            rx_ack_q;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     count_q;
    logic [7:0]      count8;

    logic full, empty;
    logic pop, flush;
    logic push_req, push;
    logic can_accept;
    logic overrun;
    logic unused_dbus_in;

    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign count8 = 8'(count_q);

    assign pop   = CS && dbus_re && !dbus_we && (dbus_addr == ADDR_RDR) && !empty;
    assign flush = CS && dbus_we && (dbus_addr == ADDR_CTRL) && dbus_in[0];

    assign unused_dbus_in = ^dbus_in[31:1];

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_q;
    logic overrun_set, overrun_clr;

    assign can_accept  = 1'b1;
    // A byte arriving while full with no pop frees no slot: it is acked but dropped.
    assign push        = push_req && !flush && (!full || pop);
    assign overrun_set = push_req && full && !pop;
    assign overrun_clr = flush || (CS && dbus_we && (dbus_addr == ADDR_SSR) && dbus_in[2]);
    assign overrun     = overrun_q;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            overrun_q <= 1'b0;
        else if (overrun_set)
            overrun_q <= 1'b1;
        else if (overrun_clr)
            overrun_q <= 1'b0;
    end
`else
    // Backpressure mode: stay in IDLE while full unless this cycle's pop frees a slot.
    assign can_accept = !full || pop;
    assign push       = push_req && !flush;
    assign overrun    = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && can_accept) begin
                    state_d  = ST_ACK;
                    push_req = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (!rx_valid)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            rx_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_ack_q <= (state_d == ST_ACK);
        end
    end

    assign rx_ack = rx_ack_q;

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr_q] <= rx_data;
    end

    always_comb begin
        dbus_out = '0;
        if (CS) begin
            case (dbus_addr)
                ADDR_RDR: begin
                    if (!empty)
                        dbus_out = {24'b0, mem[rd_ptr_q]};
                end
                ADDR_SSR: dbus_out = {16'b0, count8, 5'b0, overrun, full, !empty};
                default:  dbus_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a directed vector table for basic intake and register reads,
// followed by hand-written sequences for full, same-cycle pop/push, flush and mid-handshake reset.
module tb_uart_rx_fifo;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ack;
    logic        CS;
    logic        dbus_we;
    logic        dbus_re;
    logic [3:0]  dbus_addr;
    logic [31:0] dbus_in;
    logic [31:0] dbus_out;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ack   (rx_ack),
        .CS       (CS),
        .dbus_we  (dbus_we),
        .dbus_re  (dbus_re),
        .dbus_addr(dbus_addr),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rx_valid;
        logic [7:0]  rx_data;
        logic        cs;
        logic        re;
        logic [3:0]  addr;
        logic        exp_ack;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rv, input logic [7:0] d, input logic cs, input logic re,
                           input logic [3:0] a, input logic ack, input logic [31:0] dout);
        vec_t v;
        v.rx_valid = rv;
        v.rx_data  = d;
        v.cs       = cs;
        v.re       = re;
        v.addr     = a;
        v.exp_ack  = ack;
        v.exp_dout = dout;
        vecs.push_back(v);
    endtask

    task automatic bus_idle();
        CS        = 1'b0;
        dbus_we   = 1'b0;
        dbus_re   = 1'b0;
        dbus_addr = 4'h0;
        dbus_in   = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic do_pop, output logic [31:0] d);
        @(negedge clk_in);
        CS        = 1'b1;
        dbus_addr = a;
        dbus_re   = do_pop;
        #1 d = dbus_out;
        @(posedge clk_in);
        #1 bus_idle();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] data);
        @(negedge clk_in);
        CS        = 1'b1;
        dbus_we   = 1'b1;
        dbus_addr = a;
        dbus_in   = data;
        @(posedge clk_in);
        #1 bus_idle();
    endtask

    task automatic check_ssr(input string name, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(4'hC, 1'b0, d);
        check(name, d, exp);
    endtask

    task automatic check_rdr_pop(input string name, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(4'h4, 1'b1, d);
        check(name, d, exp);
    endtask

    // Present one byte, wait (bounded) for its ack, then release rx_valid and let the FSM return to IDLE.
    task automatic push_byte(input logic [7:0] b);
        logic seen;
        seen = 1'b0;
        @(negedge clk_in);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk_in);
            if (rx_ack) seen = 1'b1;
        end
        check($sformatf("ack for byte 0x%02h", b), {31'b0, seen}, 32'h1);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        int acks;

        rst_in   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        bus_idle();
        repeat (2) @(posedge clk_in);

        // Vector table: reset state, single-byte intake with rx_valid held 10 cycles, register decode.
        add_vec(0, 8'h00, 1, 0, 4'hC, 0, 32'h0000_0000);
        add_vec(0, 8'h00, 1, 0, 4'h4, 0, 32'h0000_0000);
        add_vec(0, 8'h00, 0, 0, 4'hC, 0, 32'h0000_0000);
        add_vec(1, 8'h41, 1, 0, 4'hC, 0, 32'h0000_0000);
        add_vec(1, 8'h41, 1, 0, 4'hC, 1, 32'h0000_0101);
        add_vec(1, 8'h41, 1, 0, 4'h4, 0, 32'h0000_0041);
        add_vec(1, 8'h41, 1, 0, 4'h8, 0, 32'h0000_0000);
        add_vec(1, 8'h41, 1, 0, 4'h0, 0, 32'h0000_0000);
        add_vec(1, 8'h41, 0, 0, 4'h4, 0, 32'h0000_0000);
        add_vec(1, 8'h41, 1, 0, 4'hC, 0, 32'h0000_0101);
        add_vec(1, 8'h41, 1, 0, 4'hC, 0, 32'h0000_0101);
        add_vec(1, 8'h41, 1, 0, 4'hC, 0, 32'h0000_0101);
        add_vec(1, 8'h41, 1, 0, 4'hC, 0, 32'h0000_0101);
        add_vec(0, 8'h00, 1, 1, 4'h4, 0, 32'h0000_0041);
        add_vec(0, 8'h00, 1, 0, 4'hC, 0, 32'h0000_0000);
        add_vec(0, 8'h00, 1, 1, 4'h4, 0, 32'h0000_0000);
        add_vec(0, 8'h00, 1, 0, 4'hC, 0, 32'h0000_0000);

        @(negedge clk_in);
        rst_in = 1'b0;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk_in);
            rx_valid  = vecs[i].rx_valid;
            rx_data   = vecs[i].rx_data;
            CS        = vecs[i].cs;
            dbus_re   = vecs[i].re;
            dbus_addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d rx_ack", i), {31'b0, rx_ack}, {31'b0, vecs[i].exp_ack});
            check($sformatf("vec%0d dbus_out", i), dbus_out, vecs[i].exp_dout);
        end
        @(posedge clk_in);
        #1 bus_idle();
        rx_valid = 1'b0;

        // Fill to DEPTH.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_ssr("ssr full", 32'h0000_1003);

`ifdef UART_RX_FIFO_OVERRUN_EN
        push_byte(8'hA5);
        check_ssr("ssr overrun", 32'h0000_1007);
        bus_write(4'hC, 32'h0000_0004);
        check_ssr("ssr overrun cleared", 32'h0000_1003);
`else
        @(negedge clk_in);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        acks     = 0;
        repeat (5) begin
            @(negedge clk_in);
            if (rx_ack) acks++;
        end
        check("no ack while full", 32'(acks), 32'h0);
        check_ssr("ssr full backpressured", 32'h0000_1003);
`endif

        // Pop and push in the same cycle at the full boundary.
        @(negedge clk_in);
        rx_valid  = 1'b1;
        rx_data   = 8'hA5;
        CS        = 1'b1;
        dbus_addr = 4'h4;
        dbus_re   = 1'b1;
        #1 check("pop at full", dbus_out, 32'h0000_0000);
        @(posedge clk_in);
        #1 bus_idle();
        @(negedge clk_in);
        check("ack on pop+push", {31'b0, rx_ack}, 32'h1);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        check_ssr("ssr after pop+push", 32'h0000_1003);
        for (int i = 1; i < 16; i++) check_rdr_pop($sformatf("drain %0d", i), 32'(i));
        check_rdr_pop("drain wrapped byte", 32'h0000_00A5);
        check_ssr("ssr drained", 32'h0000_0000);

        // Flush racing an incoming push.
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        check_ssr("ssr five", 32'h0000_0501);
        @(negedge clk_in);
        rx_valid  = 1'b1;
        rx_data   = 8'h77;
        CS        = 1'b1;
        dbus_we   = 1'b1;
        dbus_addr = 4'h0;
        dbus_in   = 32'h0000_0001;
        @(posedge clk_in);
        #1 bus_idle();
        @(negedge clk_in);
        check("ack during flush", {31'b0, rx_ack}, 32'h1);
        rx_valid = 1'b0;
        check_ssr("ssr after flush", 32'h0000_0000);
        repeat (2) @(negedge clk_in);
        push_byte(8'h33);
        check_rdr_pop("rdr after flush", 32'h0000_0033);
        push_byte(8'h55);

        // Reset asserted during the ACK cycle with rx_valid still held.
        @(negedge clk_in);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        @(negedge clk_in);
        check("ack before reset", {31'b0, rx_ack}, 32'h1);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("ack after reset", {31'b0, rx_ack}, 32'h0);
        CS        = 1'b1;
        dbus_addr = 4'hC;
        #1 check("ssr after reset", dbus_out, 32'h0000_0000);
        bus_idle();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("ack re-accept", {31'b0, rx_ack}, 32'h1);
        acks = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (rx_ack) acks++;
        end
        check("single re-accept", 32'(acks), 32'h0);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        check_ssr("ssr re-accept", 32'h0000_0101);
        check_rdr_pop("rdr re-accept", 32'h0000_0099);
        check_ssr("ssr end", 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
